stage_scheduler: RTL and testbench

- Shares one processing_stage instance between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshake on the request side.
- Programs the stage's enable and stage_type, draining in-flight operations before any type change.
- Tags each issued word and routes the stage result back to the originating requester.

---
 rtl/dsp_pipe_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/stage_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_stage_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared types for the stage scheduler: FSM state encoding and the result-routing tag.
package dsp_pipe_pkg;

   localparam int STAGE_TYPE_W = 3;
   // Wide enough for the largest supported requester count (8).
   localparam int TAG_ID_W     = 3;

   typedef enum logic [1:0] {
      OFF,
      IDLE,
      ISSUE,
      DRAIN
   } sched_state_t;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping,
// and moves the pointer just past the winner when the grant is consumed.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       any_req
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] ptr_reg;

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // Walk offsets downwards so the smallest offset from the pointer wins.
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[wrap_idx(ptr_reg, k)]) winner = wrap_idx(ptr_reg, k);
      end
   end

   assign any_req = |req;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = any_req && (winner == IDX_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
      end
   end

endmodule

// File: rtl/stage_scheduler.sv
// Shares one processing stage between NUM_REQ requesters: arbitrates, retypes the stage
// only when it is empty, tags each issued word and routes results back to their owner.
module stage_scheduler
   import dsp_pipe_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REQ       = 4,
   parameter int STAGE_LATENCY = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*3-1:0]          req_type,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         stg_data_in,
   output logic                          stg_valid_in,
   output logic                          stg_enable,
   output logic [2:0]                    stg_type,
   input  logic [DATA_WIDTH-1:0]         stg_data_out,
   input  logic                          stg_valid_out,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          op_count,
   output logic [CNT_WIDTH-1:0]          retype_count,
   output logic                          err_sticky
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int IF_W  = $clog2(STAGE_LATENCY + 3);
   localparam int FL_W  = $clog2(STAGE_LATENCY + 1);

   sched_state_t              state_reg;
   logic                      stg_enable_reg;
   logic [STAGE_TYPE_W-1:0]   stg_type_reg;
   logic [CNT_WIDTH-1:0]      op_count_reg;
   logic [CNT_WIDTH-1:0]      retype_count_reg;
   logic [IF_W-1:0]           in_flight_reg;
   logic                      stg_valid_in_reg;
   logic [DATA_WIDTH-1:0]     stg_data_in_reg;
   logic [TAG_ID_W-1:0]       issue_id_reg;
   tag_t                      tag_pipe_reg [STAGE_LATENCY];
   logic [FL_W-1:0]           flush_cnt_reg;
   logic [NUM_REQ-1:0]        rsp_valid_reg;
   logic [DATA_WIDTH-1:0]     rsp_data_reg;
   logic                      err_sticky_reg;

   logic [DATA_WIDTH-1:0]     data_arr [NUM_REQ];
   logic [STAGE_TYPE_W-1:0]   type_arr [NUM_REQ];
   logic [NUM_REQ-1:0]        grant;
   logic [IDX_W-1:0]          winner;
   logic                      any_req;
   logic                      type_match;
   logic                      accept;
   tag_t                      head;
   logic                      stage_live;
   logic                      rsp_fire;
   logic [NUM_REQ-1:0]        rsp_hit;
   logic                      rsp_any;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign type_arr[gi] = req_type[gi*STAGE_TYPE_W +: STAGE_TYPE_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant),
      .winner  (winner),
      .any_req (any_req)
   );

   assign type_match = (type_arr[winner] == stg_type_reg);
   assign accept     = (state_reg == ISSUE) && cfg_enable && any_req && type_match;
   assign req_ready  = grant & {NUM_REQ{accept}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= OFF;
         stg_enable_reg   <= 1'b0;
         stg_type_reg     <= '0;
         retype_count_reg <= '0;
         op_count_reg     <= '0;
      end else begin
         case (state_reg)
            OFF: begin
               if (cfg_enable) begin
                  state_reg      <= IDLE;
                  stg_enable_reg <= 1'b1;
               end
            end
            IDLE: begin
               if (!cfg_enable) begin
                  state_reg      <= OFF;
                  stg_enable_reg <= 1'b0;
               end else if (any_req) begin
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               if (!cfg_enable) begin
                  state_reg <= DRAIN;
               end else if (!any_req) begin
                  state_reg <= IDLE;
               end else if (!type_match) begin
                  // Retype only an empty stage; otherwise let it drain first.
                  if (in_flight_reg == '0) begin
                     stg_type_reg <= type_arr[winner];
                     if (retype_count_reg != '1)
                        retype_count_reg <= retype_count_reg + CNT_WIDTH'(1);
                  end else begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (in_flight_reg == '0) begin
                  if (cfg_enable) begin
                     state_reg <= ISSUE;
                  end else begin
                     state_reg      <= OFF;
                     stg_enable_reg <= 1'b0;
                  end
               end
            end
            default: state_reg <= OFF;
         endcase
         if (accept && (op_count_reg != '1))
            op_count_reg <= op_count_reg + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid_in_reg <= 1'b0;
         stg_data_in_reg  <= '0;
         issue_id_reg     <= '0;
      end else begin
         stg_valid_in_reg <= accept;
         if (accept) begin
            stg_data_in_reg <= data_arr[winner];
            issue_id_reg    <= TAG_ID_W'(winner);
         end
      end
   end

   // The tag enters the pipe on the same edge the stage captures its input word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGE_LATENCY; i++) tag_pipe_reg[i] <= '0;
      end else begin
         tag_pipe_reg[0] <= {stg_valid_in_reg, issue_id_reg};
         for (int i = 1; i < STAGE_LATENCY; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
   end

   assign head = tag_pipe_reg[STAGE_LATENCY-1];

   // Results still inside the stage at reset surface for up to STAGE_LATENCY cycles; mask them.
   assign stage_live = stg_valid_out && (flush_cnt_reg == '0);
   assign rsp_fire   = stage_live && head.valid;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_hit
      assign rsp_hit[gi] = (head.id == TAG_ID_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_reg  <= FL_W'(STAGE_LATENCY);
         rsp_valid_reg  <= '0;
         rsp_data_reg   <= '0;
         err_sticky_reg <= 1'b0;
      end else begin
         if (flush_cnt_reg != '0) flush_cnt_reg <= flush_cnt_reg - FL_W'(1);
         rsp_valid_reg <= rsp_fire ? rsp_hit : '0;
         if (rsp_fire) rsp_data_reg <= stg_data_out;
         if (stage_live != head.valid) err_sticky_reg <= 1'b1;
      end
   end

   assign rsp_any = |rsp_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_flight_reg <= '0;
      end else if (accept && !rsp_any) begin
         in_flight_reg <= in_flight_reg + IF_W'(1);
      end else if (!accept && rsp_any) begin
         in_flight_reg <= in_flight_reg - IF_W'(1);
      end
   end

   assign stg_data_in  = stg_data_in_reg;
   assign stg_valid_in = stg_valid_in_reg;
   assign stg_enable   = stg_enable_reg;
   assign stg_type     = stg_type_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_data     = rsp_data_reg;
   assign busy         = (state_reg == ISSUE) || (state_reg == DRAIN) || (in_flight_reg != '0);
   assign op_count     = op_count_reg;
   assign retype_count = retype_count_reg;
   assign err_sticky   = err_sticky_reg;

endmodule

// File: tb/tb_stage_scheduler.sv
// Directed bench for stage_scheduler with a one-cycle "add STAGE_ID" stage model.
module tb_stage_scheduler;

   localparam int DW  = 32;
   localparam int NR  = 4;
   localparam int LAT = 1;
   localparam int CW  = 16;
   localparam logic [DW-1:0] STAGE_ID = 32'h0000_1000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_enable = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR*3-1:0]   req_type = '0;
   logic [NR-1:0]     req_ready;
   logic [DW-1:0]     stg_data_in;
   logic              stg_valid_in;
   logic              stg_enable;
   logic [2:0]        stg_type;
   logic [DW-1:0]     stg_data_out = '0;
   logic              stg_valid_out = 1'b0;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              busy;
   logic [CW-1:0]     op_count;
   logic [CW-1:0]     retype_count;
   logic              err_sticky;
   logic              inject = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [NR-1:0] v;
      logic [DW-1:0] d;
      int            c;
   } rsp_t;
   rsp_t rsp_q[$];

   always #5 clk = ~clk;

   stage_scheduler #(
      .DATA_WIDTH(DW), .NUM_REQ(NR), .STAGE_LATENCY(LAT), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
      .req_valid(req_valid), .req_data(req_data), .req_type(req_type), .req_ready(req_ready),
      .stg_data_in(stg_data_in), .stg_valid_in(stg_valid_in), .stg_enable(stg_enable),
      .stg_type(stg_type), .stg_data_out(stg_data_out), .stg_valid_out(stg_valid_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .op_count(op_count), .retype_count(retype_count), .err_sticky(err_sticky)
   );

   // Stage model: not reset, so words in flight at reset still emerge afterwards.
   always @(posedge clk) begin
      stg_valid_out <= stg_valid_in | inject;
      stg_data_out  <= stg_data_in + STAGE_ID;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         rsp_q.push_back('{rsp_valid, rsp_data, cyc});
         $display("rsp cyc=%0d valid=%b data=%h", cyc, rsp_valid, rsp_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      inject = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({req_ready, stg_valid_in, stg_enable, stg_type, rsp_valid, busy, err_sticky} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got %h expected 0",
                  {req_ready, stg_valid_in, stg_enable, stg_type, rsp_valid, busy, err_sticky});
      end
      checks++;
      if ({stg_data_in, rsp_data, op_count, retype_count} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {stg_data_in, rsp_data, op_count, retype_count});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      req_data[0 +: DW] = 32'h10;
      req_type = '0;
      req_valid = 4'b0001;
      cfg_enable = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL single_off_ready: got %b expected 0000", req_ready);
      end
      step(); #1;
      checks++;
      if ({stg_enable, req_ready} !== 5'b1_0000) begin
         errors++; $display("FAIL single_idle: got %b expected 10000", {stg_enable, req_ready});
      end
      step(); #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_ready: got %b expected 0001", req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if ({stg_valid_in, stg_data_in, op_count} !== {1'b1, 32'h10, 16'd1}) begin
         errors++;
         $display("FAIL single_issue: got v=%b d=%h n=%0d expected v=1 d=10 n=1",
                  stg_valid_in, stg_data_in, op_count);
      end
      step();
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL single_rsp_early: got %b expected 0000", rsp_valid);
      end
      step();
      checks++;
      if ({rsp_valid, rsp_data} !== {4'b0001, 32'h1010}) begin
         errors++; $display("FAIL single_rsp: got %b/%h expected 0001/00001010", rsp_valid, rsp_data);
      end
      step();
      checks++;
      if ({busy, rsp_valid} !== 5'b0) begin
         errors++; $display("FAIL single_idle_after: got busy=%b rsp=%b expected 0/0000", busy, rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [NR-1:0] exp_v;
      do_reset();
      rsp_q.delete();
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h40 + i;
      req_type = '0;
      req_valid = 4'b1111;
      cfg_enable = 1'b1;
      step();
      step();
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_v = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== exp_v) begin
            errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, req_ready, exp_v);
         end
         step();
      end
      req_valid = '0;
      repeat (6) step();
      checks++;
      if (rsp_q.size() != 8) begin
         errors++; $display("FAIL b2b_rsp_count: got %0d expected 8", rsp_q.size());
      end
      for (int k = 0; k < 8 && k < rsp_q.size(); k++) begin
         exp_v = 4'b0001 << (k % 4);
         checks++;
         if ({rsp_q[k].v, rsp_q[k].d} !== {exp_v, 32'h1040 + 32'(k % 4)} || rsp_q[k].c != rsp_q[0].c + k) begin
            errors++;
            $display("FAIL b2b_rsp[%0d]: got %b/%h @%0d expected %b/%h @%0d", k, rsp_q[k].v, rsp_q[k].d,
                     rsp_q[k].c, exp_v, 32'h1040 + 32'(k % 4), rsp_q[0].c + k);
         end
      end
      checks++;
      if (op_count !== 16'd8) begin
         errors++; $display("FAIL b2b_op_count: got %0d expected 8", op_count);
      end
   endtask

   task automatic test_retype();
      logic [NR-1:0] exp_rdy [13];
      logic [NR-1:0] got;
      exp_rdy = '{4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100,
                  4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0010};
      do_reset();
      rsp_q.delete();
      req_data[1*DW +: DW] = 32'h51;
      req_data[2*DW +: DW] = 32'h52;
      req_type = '0;
      req_type[2*3 +: 3] = 3'd5;
      req_valid = 4'b0110;
      cfg_enable = 1'b1;
      step();
      step();
      for (int k = 0; k < 13; k++) begin
         #1;
         checks++;
         if (req_ready !== exp_rdy[k]) begin
            errors++; $display("FAIL retype_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy[k]);
         end
         if (k == 5) begin
            checks++;
            if ({stg_type, retype_count} !== {3'd0, 16'd0}) begin
               errors++; $display("FAIL retype_hold: got t=%0d n=%0d expected t=0 n=0", stg_type, retype_count);
            end
         end
         if (k == 6) begin
            checks++;
            if ({stg_type, retype_count} !== {3'd5, 16'd1}) begin
               errors++; $display("FAIL retype_first: got t=%0d n=%0d expected t=5 n=1", stg_type, retype_count);
            end
         end
         if (k == 12) begin
            checks++;
            if ({stg_type, retype_count} !== {3'd0, 16'd2}) begin
               errors++; $display("FAIL retype_back: got t=%0d n=%0d expected t=0 n=2", stg_type, retype_count);
            end
         end
         got = req_ready;
         step();
         if (got[2]) req_valid[2] = 1'b0;
      end
      req_valid = '0;
      repeat (6) step();
      checks++;
      if (rsp_q.size() != 3) begin
         errors++; $display("FAIL retype_rsp_count: got %0d expected 3", rsp_q.size());
      end else begin
         checks++;
         if ({rsp_q[0].v, rsp_q[0].d, rsp_q[1].v, rsp_q[1].d, rsp_q[2].v, rsp_q[2].d} !==
             {4'b0010, 32'h1051, 4'b0100, 32'h1052, 4'b0010, 32'h1051}) begin
            errors++;
            $display("FAIL retype_rsp: got %b/%h %b/%h %b/%h expected 0010/1051 0100/1052 0010/1051",
                     rsp_q[0].v, rsp_q[0].d, rsp_q[1].v, rsp_q[1].d, rsp_q[2].v, rsp_q[2].d);
         end
      end
   endtask

   task automatic test_cfg_drop();
      do_reset();
      rsp_q.delete();
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h60 + i;
      req_type = '0;
      req_valid = 4'b1111;
      cfg_enable = 1'b1;
      step();
      step();
      repeat (3) step();
      cfg_enable = 1'b0;
      #1;
      checks++;
      if ({req_ready, busy} !== 5'b0000_1) begin
         errors++; $display("FAIL cfgdrop_ready: got rdy=%b busy=%b expected 0000/1", req_ready, busy);
      end
      repeat (3) step();
      checks++;
      if ({stg_enable, busy, req_ready} !== 6'b11_0000) begin
         errors++; $display("FAIL cfgdrop_drain: got en=%b busy=%b rdy=%b expected 1/1/0000",
                            stg_enable, busy, req_ready);
      end
      step();
      checks++;
      if ({stg_enable, busy, req_ready} !== 6'b00_0000) begin
         errors++; $display("FAIL cfgdrop_off: got en=%b busy=%b rdy=%b expected 0/0/0000",
                            stg_enable, busy, req_ready);
      end
      checks++;
      if (rsp_q.size() != 3) begin
         errors++; $display("FAIL cfgdrop_rsp_count: got %0d expected 3", rsp_q.size());
      end else begin
         checks++;
         if ({rsp_q[0].v, rsp_q[0].d, rsp_q[1].v, rsp_q[1].d, rsp_q[2].v, rsp_q[2].d} !==
             {4'b0001, 32'h1060, 4'b0010, 32'h1061, 4'b0100, 32'h1062}) begin
            errors++;
            $display("FAIL cfgdrop_rsp: got %b/%h %b/%h %b/%h expected 0001/1060 0010/1061 0100/1062",
                     rsp_q[0].v, rsp_q[0].d, rsp_q[1].v, rsp_q[1].d, rsp_q[2].v, rsp_q[2].d);
         end
      end
      cfg_enable = 1'b1;
      req_valid = '0;
      step();
      checks++;
      if ({stg_enable, req_ready} !== 5'b1_0000) begin
         errors++; $display("FAIL cfgdrop_reenable: got en=%b rdy=%b expected 1/0000", stg_enable, req_ready);
      end
   endtask

   task automatic test_orphan_result();
      do_reset();
      cfg_enable = 1'b0;
      rsp_q.delete();
      step();
      step();
      inject = 1'b1;
      step();
      inject = 1'b0;
      step();
      checks++;
      if ({rsp_valid, err_sticky} !== 5'b0000_1) begin
         errors++; $display("FAIL orphan_flag: got rsp=%b err=%b expected 0000/1", rsp_valid, err_sticky);
      end
      repeat (4) step();
      checks++;
      if (err_sticky !== 1'b1 || rsp_q.size() != 0) begin
         errors++; $display("FAIL orphan_persist: got err=%b rsps=%0d expected 1/0", err_sticky, rsp_q.size());
      end
      do_reset();
      checks++;
      if (err_sticky !== 1'b0) begin
         errors++; $display("FAIL orphan_clear: got %b expected 0", err_sticky);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rsp_q.delete();
      req_data[0*DW +: DW] = 32'h70;
      req_data[1*DW +: DW] = 32'h71;
      req_type = '0;
      req_valid = 4'b0011;
      cfg_enable = 1'b1;
      step();
      step();
      step();
      step();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
      checks++;
      if ({req_ready, stg_valid_in, stg_enable, stg_type, rsp_valid, busy, err_sticky} !== '0) begin
         errors++;
         $display("FAIL midrst_ctrl: got %h expected 0",
                  {req_ready, stg_valid_in, stg_enable, stg_type, rsp_valid, busy, err_sticky});
      end
      checks++;
      if ({stg_data_in, rsp_data, op_count, retype_count} !== '0) begin
         errors++; $display("FAIL midrst_data: got %h expected 0", {stg_data_in, rsp_data, op_count, retype_count});
      end
      cfg_enable = 1'b0;
      repeat (5) step();
      checks++;
      if (rsp_q.size() != 0 || err_sticky !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_after: got rsps=%0d err=%b busy=%b expected 0/0/0",
                            rsp_q.size(), err_sticky, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_retype();
      test_cfg_drop();
      test_orphan_result();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
